// File: rtl/mem_arbiter_pkg.sv
// Shared state and requester encodings for the mem_arbiter block.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational request picker for mem_arbiter.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: fixed priority, requester 1 wins.
module arb_pick2
   import mem_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_valid,
   output logic o_id
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      o_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         o_id = ~i_last;
      end else begin
         o_id = i_req1 ? ID_M1 : ID_M0;
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = i_last;

   always_comb begin
      o_valid = i_req0 | i_req1;
      o_id    = i_req1 ? ID_M1 : ID_M0;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto a single-port memory: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (default: fixed priority, m1 wins).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_rwn,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_rwn,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic          mem_rwn,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          grant_id
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_valid;
   logic          w_id;
   logic          w_sel_rwn;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;

   logic          r_rr_last;
   logic          r_grant_id;
   logic          r_busy;
   logic          r_mem_rwn;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;
   logic          r_m0_ack;
   logic          r_m1_ack;

   arb_pick2 u_pick (
      .i_req0  (m0_req),
      .i_req1  (m1_req),
      .i_last  (r_rr_last),
      .o_valid (w_valid),
      .o_id    (w_id)
   );

   assign w_sel_rwn   = (w_id == ID_M1) ? m1_rwn   : m0_rwn;
   assign w_sel_addr  = (w_id == ID_M1) ? m1_addr  : m0_addr;
   assign w_sel_wdata = (w_id == ID_M1) ? m1_wdata : m0_wdata;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: next state defaults to the current state first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_valid) w_state_nxt = ST_ACCESS;
         ST_ACCESS: w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_last   <= 1'b1;
         r_grant_id  <= ID_M0;
         r_busy      <= 1'b0;
         r_mem_rwn   <= 1'b1;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_m0_ack    <= 1'b0;
         r_m1_ack    <= 1'b0;
      end else begin
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant_id  <= w_id;
                  r_mem_rwn   <= w_sel_rwn;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
`ifdef MEM_ARB_RR_EN
                  r_rr_last   <= w_id;
`endif
               end
            end
            ST_ACCESS: begin
               // mem_rdata was produced at the negedge inside this cycle; writes keep old rdata.
               if (r_mem_rwn) begin
                  if (r_grant_id == ID_M1) r_m1_rdata <= mem_rdata;
                  else                     r_m0_rdata <= mem_rdata;
               end
               if (r_grant_id == ID_M1) r_m1_ack <= 1'b1;
               else                     r_m0_ack <= 1'b1;
               r_mem_rwn <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign m0_rdata  = r_m0_rdata;
   assign m0_ack    = r_m0_ack;
   assign m1_rdata  = r_m1_rdata;
   assign m1_ack    = r_m1_ack;
   assign mem_rwn   = r_mem_rwn;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;
   assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a negedge-sampling 256x8 memory model (F8 out, F9..FF in).
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       m0_req, m0_rwn, m0_ack;
   logic [7:0] m0_addr, m0_wdata, m0_rdata;
   logic       m1_req, m1_rwn, m1_ack;
   logic [7:0] m1_addr, m1_wdata, m1_rdata;
   logic       mem_rwn, busy, grant_id;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_rwn(m0_rwn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_rwn(m1_rwn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .mem_rwn(mem_rwn), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   // Memory model: RAM below F8, F8 = output register, F9..FF = fixed input values.
   logic [7:0] mem [256];
   logic [7:0] outdataio;
   bit         mem_ready = 1'b0;

   function automatic logic [7:0] io_in(input logic [7:0] a);
      return a ^ 8'h94;
   endfunction

   always @(negedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
         mem[8'h10] <= 8'h5A;
         outdataio  <= 8'h00;
         mem_ready  <= 1'b1;
      end else if (mem_rwn === 1'b0) begin
         if (mem_addr <= 8'hF8) mem[mem_addr] <= mem_wdata;
         if (mem_addr == 8'hF8) outdataio <= mem_wdata;
      end else begin
         if (mem_addr >= 8'hF9)      mem_rdata <= io_in(mem_addr);
         else if (mem_addr == 8'hF8) mem_rdata <= outdataio;
         else                        mem_rdata <= mem[mem_addr];
      end
   end

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp0_q[$];
   logic [7:0] exp1_q[$];
   bit         ack_log[$];
   logic [7:0] last_rd [2];

   // Ack monitor: pops the expected rdata of the acked requester; also guards against stray writes.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL dual_ack: m0_ack=1 m1_ack=1, required at most one");
      end
      if (m0_ack === 1'b1) begin
         ack_log.push_back(1'b0);
         vectors++;
         if (exp0_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_ack0: m0_ack=1, required 0 (no outstanding m0 request)");
         end else begin
            e = exp0_q.pop_front();
            if (m0_rdata !== e) begin
               miscompares++;
               $display("FAIL m0_rdata: got %h, required %h", m0_rdata, e);
            end
         end
      end
      if (m1_ack === 1'b1) begin
         ack_log.push_back(1'b1);
         vectors++;
         if (exp1_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_ack1: m1_ack=1, required 0 (no outstanding m1 request)");
         end else begin
            e = exp1_q.pop_front();
            if (m1_rdata !== e) begin
               miscompares++;
               $display("FAIL m1_rdata: got %h, required %h", m1_rdata, e);
            end
         end
      end
      if (mem_rwn === 1'b0) begin
         vectors++;
         if (busy !== 1'b1 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_write: mem_rwn=0 with busy=%b acks=%b%b, required busy=1 acks=00",
                     busy, m0_ack, m1_ack);
         end
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
   endtask

   task automatic access(input bit id, input bit rwn, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rd_exp, input bit hold, output int lat);
      bit got;
      if (rwn) last_rd[id] = rd_exp;
      if (id) exp1_q.push_back(last_rd[1]);
      else    exp0_q.push_back(last_rd[0]);
      if (id) begin m1_rwn = rwn; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
      else    begin m0_rwn = rwn; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
         @(posedge clk); #1; lat++;
         got = ((id ? m1_ack : m0_ack) === 1'b1);
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL ack_timeout: m%0d got no ack within %0d cycles, required ack", id, lat);
         if (id) exp1_q.delete(); else exp0_q.delete();
      end else begin
         vectors++;
         if (grant_id !== id) begin
            miscompares++;
            $display("FAIL grant_id: got %b, required %b", grant_id, id);
         end
      end
      if (hold) begin @(posedge clk); #1; end
      if (id) m1_req = 1'b0; else m0_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset(2);
      vectors++;
      if ({mem_rwn, mem_addr, mem_wdata, m0_rdata, m0_ack, m1_rdata, m1_ack, busy, grant_id}
          !== {1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: rwn=%b addr=%h wdata=%h rd0=%h ack0=%b rd1=%h ack1=%b busy=%b gid=%b, required 1 00 00 00 0 00 0 0 0",
                  mem_rwn, mem_addr, mem_wdata, m0_rdata, m0_ack, m1_rdata, m1_ack, busy, grant_id);
      end
   endtask

   task automatic test_read_m0();
      int lat;
      access(1'b0, 1'b1, 8'h10, 8'h00, 8'h5A, 1'b0, lat);
      vectors++;
      if (lat != 2) begin
         miscompares++;
         $display("FAIL read_latency: got %0d cycles, required 2", lat);
      end
   endtask

   task automatic test_io_writes();
      int lat;
      access(1'b1, 1'b0, 8'hF8, 8'h3C, 8'h00, 1'b0, lat);
      vectors++;
      if (outdataio !== 8'h3C) begin
         miscompares++;
         $display("FAIL outdataio: got %h, required 3c", outdataio);
      end
      access(1'b0, 1'b1, 8'hF8, 8'h00, 8'h3C, 1'b0, lat);
      access(1'b1, 1'b0, 8'hFA, 8'h99, 8'h00, 1'b0, lat);
      access(1'b0, 1'b1, 8'hFA, 8'h00, 8'h6E, 1'b0, lat);
      vectors++;
      if (outdataio !== 8'h3C) begin
         miscompares++;
         $display("FAIL outdataio_after_fa: got %h, required 3c", outdataio);
      end
   endtask

   task automatic test_arbitration();
      bit exp_order [4];
      int n;
      int cyc;
      do_reset(1);
`ifdef MEM_ARB_RR_EN
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
      last_rd[0] = 8'h5A;
`else
      exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      last_rd[1] = 8'hD2;
      ack_log.delete();
      foreach (exp_order[i]) begin
         if (exp_order[i]) exp1_q.push_back(8'hD2);
         else              exp0_q.push_back(8'h5A);
      end
      m0_rwn = 1'b1; m0_addr = 8'h10; m0_wdata = 8'h00;
      m1_rwn = 1'b1; m1_addr = 8'h11; m1_wdata = 8'h00;
      m0_req = 1'b1; m1_req = 1'b1;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         @(posedge clk); #1; cyc++;
         if (m0_ack === 1'b1 || m1_ack === 1'b1) n++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if (n != 4 || ack_log.size() != 4) begin
         miscompares++;
         $display("FAIL contention_acks: got %0d acks (%0d logged) in %0d cycles, required 4",
                  n, ack_log.size(), cyc);
         exp0_q.delete(); exp1_q.delete();
      end
      for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
         vectors++;
         if (ack_log[i] != exp_order[i]) begin
            miscompares++;
            $display("FAIL grant_order[%0d]: got m%0d, required m%0d", i, ack_log[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_reset_in_access();
      int lat;
      m1_rwn = 1'b0; m1_addr = 8'h20; m1_wdata = 8'h77; m1_req = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (mem_rwn !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL access_entry: mem_rwn=%b busy=%b, required 0 1", mem_rwn, busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m1_req = 1'b0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      vectors++;
      if ({busy, m0_ack, m1_ack, mem_rwn, grant_id, m0_rdata, m1_rdata}
          !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_in_access: busy=%b acks=%b%b rwn=%b gid=%b rd0=%h rd1=%h, required 0 00 1 0 00 00",
                  busy, m0_ack, m1_ack, mem_rwn, grant_id, m0_rdata, m1_rdata);
      end
      vectors++;
      if (mem[8'h20] !== 8'h77) begin
         miscompares++;
         $display("FAIL write_landed: mem[20]=%h, required 77", mem[8'h20]);
      end
      repeat (3) begin @(posedge clk); #1; end
      access(1'b0, 1'b1, 8'h20, 8'h00, 8'h77, 1'b0, lat);
   endtask

   task automatic test_hold_through_done();
      int lat;
      int extra;
      access(1'b0, 1'b1, 8'h30, 8'h00, 8'hF3, 1'b1, lat);
      access(1'b1, 1'b0, 8'h40, 8'h12, 8'h00, 1'b1, lat);
      extra = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (m0_ack === 1'b1 || m1_ack === 1'b1) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL double_serve: got %0d extra acks, required 0", extra);
      end
      vectors++;
      if (mem[8'h40] !== 8'h12) begin
         miscompares++;
         $display("FAIL held_write: mem[40]=%h, required 12", mem[8'h40]);
      end
      access(1'b1, 1'b1, 8'h40, 8'h00, 8'h12, 1'b0, lat);
   endtask

   initial begin
      m0_req = 1'b0; m0_rwn = 1'b1; m0_addr = 8'h00; m0_wdata = 8'h00;
      m1_req = 1'b0; m1_rwn = 1'b1; m1_addr = 8'h00; m1_wdata = 8'h00;
      rst = 1'b1;
      test_reset();
      test_read_m0();
      test_io_writes();
      test_arbitration();
      test_reset_in_access();
      test_hold_through_done();
      vectors++;
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
         miscompares++;
         $display("FAIL outstanding: %0d m0 and %0d m1 expected acks never arrived, required 0 0",
                  exp0_q.size(), exp1_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
